// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALU operation classes and datapath mux select codes.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [3:0] DEFAULT_RESET_STATE = 4'd0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/riscv_multicycle_control_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath
// plus memory (slave): instruction fields and status in, selects and enables out.
interface riscv_multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr;
    logic       instr_done;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               illegal_instr, instr_done
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               illegal_instr, instr_done
    );
endinterface

// File: rtl/riscv_alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction funct fields to the ALU
// control code. Purely combinational.
module riscv_alu_decoder
    import riscv_mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op_5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi ignores instr[30]; only R-type uses it to select sub
                    3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Main control FSM for a multi-cycle RV32I-subset datapath sharing one memory.
// state    | meaning
// FETCH    | read instr at PC, PC+4 -> PC on mem_ready
// DECODE   | compute branch/jump target, dispatch on opcode
// MEMADR   | rs1 + imm -> effective address
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access, wait for mem_ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALUOut to rd
// JAL      | PC <- target, oldPC+4 -> ALUOut
// BRANCH   | compare rs1/rs2, PC <- target if taken
module riscv_multicycle_control
    import riscv_mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = DEFAULT_RESET_STATE
) (
    input  logic clk,
    input  logic reset,
    riscv_multicycle_control_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    alu_op_t    alu_op;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       taken;
    logic       legal;

    assign legal = is_supported(bus.opcode);
    assign taken = bus.zero ^ bus.funct3[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req           = 1'b0;
        mem_write         = 1'b0;
        ir_write          = 1'b0;
        pc_update         = 1'b0;
        branch            = 1'b0;
        reg_write         = 1'b0;
        alu_op            = ALUOP_ADD;
        bus.adr_src       = 1'b0;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RS2;
        bus.result_src    = RES_ALUOUT;
        bus.illegal_instr = 1'b0;
        bus.instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req        = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                ir_write       = bus.mem_ready;
                pc_update      = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a     = SRCA_OLDPC;
                bus.alu_src_b     = SRCB_IMM;
                bus.illegal_instr = !legal;
                bus.instr_done    = !legal;
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req     = 1'b1;
                bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src = RES_MEM;
                reg_write      = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req        = 1'b1;
                mem_write      = 1'b1;
                bus.adr_src    = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                alu_op        = ALUOP_FUNCT;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                alu_op        = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write      = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_update     = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = SRCA_RS1;
                alu_op         = ALUOP_SUB;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OP_STORE:  bus.imm_src = IMM_S;
            OP_BRANCH: bus.imm_src = IMM_B;
            OP_JAL:    bus.imm_src = IMM_J;
            default:   bus.imm_src = IMM_I;
        endcase
    end

    // Reset asserted must silence memory and all architectural writes at once,
    // even though FETCH itself would request memory.
    assign bus.mem_req   = reset & mem_req;
    assign bus.mem_write = reset & mem_write;
    assign bus.ir_write  = reset & ir_write;
    assign bus.pc_write  = reset & (pc_update | (branch & taken));
    assign bus.reg_write = reset & reg_write;

    riscv_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op_5        (bus.opcode[5]),
        .funct7_5    (bus.funct7_5),
        .alu_control (bus.alu_control)
    );

endmodule
